rc4_keystream_decryptor: RTL

RC4_KEYSTREAM_DECRYPTOR -- requirements
Module: rc4_keystream_decryptor

---
 rtl/rc4_keystream_decryptor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rc4_keystream_decryptor.sv
// RC4 PRGA engine: walks the S-box held in an external RAM, XORs each keystream
// byte with the encrypted ROM message and writes the plaintext to a result RAM.
module rc4_keystream_decryptor #(
    parameter int RAM_WIDTH = 8,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 finished,
    output logic [7:0]           s_address,
    output logic [RAM_WIDTH-1:0] s_data,
    output logic                 s_wren,
    input  logic [RAM_WIDTH-1:0] s_q,
    output logic [MSG_AW-1:0]    rom_address,
    input  logic [RAM_WIDTH-1:0] rom_q,
    output logic [MSG_AW-1:0]    res_address,
    output logic [RAM_WIDTH-1:0] res_data,
    output logic                 res_wren
);

    typedef enum logic [3:0] {
        IDLE,
        READ_I,
        WAIT_I,
        LATCH_I,
        WAIT_J,
        LATCH_J,
        WRITE_I,
        WRITE_J,
        READ_F,
        WAIT_F,
        WRITE_RES,
        DONE
    } state_t;

    localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

    state_t                 state, next_state;
    logic [7:0]             i, j, i_d, j_d;
    logic [MSG_AW-1:0]      k, k_d;
    logic [RAM_WIDTH-1:0]   si, sj, si_d, sj_d;

    logic [7:0]             s_address_d;
    logic [RAM_WIDTH-1:0]   s_data_d, res_data_d;
    logic                   s_wren_d, res_wren_d, busy_d, finished_d;
    logic [MSG_AW-1:0]      rom_address_d, res_address_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: ten fixed states per message byte
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = READ_I;
            READ_I:    next_state = WAIT_I;
            WAIT_I:    next_state = LATCH_I;
            LATCH_I:   next_state = WAIT_J;
            WAIT_J:    next_state = LATCH_J;
            LATCH_J:   next_state = WRITE_I;
            WRITE_I:   next_state = WRITE_J;
            WRITE_J:   next_state = READ_F;
            READ_F:    next_state = WAIT_F;
            WAIT_F:    next_state = WRITE_RES;
            WRITE_RES: next_state = (k == LAST_K) ? DONE : READ_I;
            DONE:      if (!start) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output logic: each state's action becomes visible on the edge that leaves it,
    // so the wait states give the synchronous RAM its one cycle of read latency.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        i_d           = i;
        j_d           = j;
        k_d           = k;
        si_d          = si;
        sj_d          = sj;
        s_address_d   = s_address;
        s_data_d      = s_data;
        rom_address_d = rom_address;
        res_address_d = res_address;
        res_data_d    = res_data;
        s_wren_d      = 1'b0;
        res_wren_d    = 1'b0;
        busy_d        = (state != IDLE) && (state != DONE);
        finished_d    = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    i_d = 8'd0;
                    j_d = 8'd0;
                    k_d = '0;
                end
            end
            READ_I: begin
                i_d         = i + 8'd1;
                s_address_d = i + 8'd1;
            end
            LATCH_I: begin
                si_d        = s_q;
                j_d         = j + 8'(s_q);
                s_address_d = j + 8'(s_q);
            end
            LATCH_J: begin
                sj_d = s_q;
            end
            WRITE_I: begin
                s_address_d = i;
                s_data_d    = sj;
                s_wren_d    = 1'b1;
            end
            WRITE_J: begin
                s_address_d = j;
                s_data_d    = si;
                s_wren_d    = 1'b1;
            end
            READ_F: begin
                s_address_d   = 8'(si + sj);
                rom_address_d = k;
            end
            WRITE_RES: begin
                res_address_d = k;
                res_data_d    = s_q ^ rom_q;
                res_wren_d    = 1'b1;
                if (k != LAST_K) k_d = k + MSG_AW'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i           <= 8'd0;
            j           <= 8'd0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            s_address   <= 8'd0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            res_address <= '0;
            res_data    <= '0;
            res_wren    <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            i           <= i_d;
            j           <= j_d;
            k           <= k_d;
            si          <= si_d;
            sj          <= sj_d;
            s_address   <= s_address_d;
            s_data      <= s_data_d;
            s_wren      <= s_wren_d;
            rom_address <= rom_address_d;
            res_address <= res_address_d;
            res_data    <= res_data_d;
            res_wren    <= res_wren_d;
            busy        <= busy_d;
            finished    <= finished_d;
        end
    end

endmodule
